// File: rtl/seq_detector.sv
// ============================================================================
//  Module   : seq_detector
//  Purpose  : Serial pattern detector with fill FSM, match pulse and
//             saturating match counter. Define SEQ_OVERLAP_EN for
//             overlapping detection (default: non-overlapping).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             d,
   output logic [PAT_W-1:0] hist,
   output logic             full,
   output logic             match,
   output logic [CNT_W-1:0] count
);

   localparam int                c_FILL_W   = $clog2(PAT_W + 1);
   localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(PAT_W);
`ifdef SEQ_OVERLAP_EN
   localparam logic [c_FILL_W-1:0] c_FILL_AFTER_HIT = c_FILL_MAX;
`else
   localparam logic [c_FILL_W-1:0] c_FILL_AFTER_HIT = '0;
`endif

   typedef enum logic [0:0] {
      ST_FILLING = 1'b0,
      ST_FULL    = 1'b1
   } state_t;

   state_t              r_state;
   logic [c_FILL_W-1:0] r_fill;
   logic [PAT_W-1:0]    r_hist;
   logic                r_match;
   logic [CNT_W-1:0]    r_count;

   logic [PAT_W-1:0]    w_hist_n;
   logic [c_FILL_W-1:0] w_fill_n;
   logic [c_FILL_W-1:0] w_fill_nxt;
   logic                w_hit;
   logic                w_count_max;

   assign w_hist_n    = {r_hist[PAT_W-2:0], d};
   assign w_fill_n    = (r_fill == c_FILL_MAX) ? r_fill : r_fill + c_FILL_W'(1);
   // Requiring a full window of sampled bits keeps the reset history from matching.
   assign w_hit       = (w_fill_n == c_FILL_MAX) && (w_hist_n == PATTERN);
   assign w_fill_nxt  = w_hit ? c_FILL_AFTER_HIT : w_fill_n;
   assign w_count_max = &r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_FILLING;
         r_fill  <= '0;
         r_hist  <= '0;
         r_match <= 1'b0;
         r_count <= '0;
      end else if (en) begin
         r_hist  <= w_hist_n;
         r_match <= w_hit;
         r_fill  <= w_fill_nxt;
         r_state <= (w_fill_nxt == c_FILL_MAX) ? ST_FULL : ST_FILLING;
         if (w_hit && !w_count_max)
            r_count <= r_count + CNT_W'(1);
      end else begin
         r_match <= 1'b0;
      end
   end

   assign hist  = r_hist;
   assign full  = (r_state == ST_FULL);
   assign match = r_match;
   assign count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_seq_detector.sv
// ============================================================================
//  Module   : tb_seq_detector
//  Purpose  : Directed self-checking bench for seq_detector (three builds:
//             1011/CNT8, 0000/CNT8, 1111/CNT2); honours SEQ_OVERLAP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detector;

`ifdef SEQ_OVERLAP_EN
   localparam bit OV = 1'b1;
`else
   localparam bit OV = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, en, d;
   always #5 clk = ~clk;

   logic [3:0] hist0, hist1, hist2;
   logic       full0, full1, full2;
   logic       match0, match1, match2;
   logic [7:0] count0, count1;
   logic [1:0] count2;

   int n_tests = 0;
   int n_fail  = 0;

   seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut0 (
      .clk(clk), .rst(rst), .en(en), .d(d),
      .hist(hist0), .full(full0), .match(match0), .count(count0));

   seq_detector #(.PAT_W(4), .PATTERN(4'b0000), .CNT_W(8)) dut1 (
      .clk(clk), .rst(rst), .en(en), .d(d),
      .hist(hist1), .full(full1), .match(match1), .count(count1));

   seq_detector #(.PAT_W(4), .PATTERN(4'b1111), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .d(d),
      .hist(hist2), .full(full2), .match(match2), .count(count2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic e, input logic b);
      @(negedge clk);
      rst = 1'b0; en = e; d = b;
      @(posedge clk);
      #1;
   endtask

   task automatic do_rst(input logic e, input logic b);
      @(negedge clk);
      rst = 1'b1; en = e; d = b;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit sb[7] = '{1, 0, 1, 1, 0, 1, 1};
      bit em[7] = '{0, 0, 0, 1, 0, 0, OV};
      logic [3:0] eh[7] = '{4'h1, 4'h2, 4'h5, 4'hB, 4'h6, 4'hD, 4'hB};
      bit ef[7] = '{0, 0, 0, OV, OV, OV, OV};
      bit gd[3] = '{1, 0, 1};
      bit zm[5] = '{0, 0, 0, 1, OV};
      int hits;
      int nones;
      bit exp_m;

      rst = 1'b0; en = 1'b0; d = 1'b0;

      // Reset wins over a simultaneous enabled bit.
      do_rst(1'b1, 1'b1);
      chk("rst_hist",  32'(hist0),  32'h0);
      chk("rst_full",  32'(full0),  32'h0);
      chk("rst_match", 32'(match0), 32'h0);
      chk("rst_count", 32'(count0), 32'h0);

      // Stream 1,0,1,1,0,1,1 against 1011.
      for (int i = 0; i < 7; i++) begin
         step(1'b1, sb[i]);
         chk($sformatf("s1_match%0d", i), 32'(match0), 32'(em[i]));
         chk($sformatf("s1_hist%0d", i),  32'(hist0),  32'(eh[i]));
         chk($sformatf("s1_full%0d", i),  32'(full0),  32'(ef[i]));
      end
      chk("s1_count", 32'(count0), OV ? 32'd2 : 32'd1);
      step(1'b0, 1'b1);
      chk("s1_pulse_end", 32'(match0), 32'h0);

      // Enable gaps: gated cycles must not disturb history.
      do_rst(1'b0, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, gd[i]);
         chk($sformatf("gap_hist%0d", i),  32'(hist0),  32'h2);
         chk($sformatf("gap_match%0d", i), 32'(match0), 32'h0);
      end
      step(1'b1, 1'b1);
      chk("gap_nomatch", 32'(match0), 32'h0);
      step(1'b1, 1'b1);
      chk("gap_match", 32'(match0), 32'h1);
      chk("gap_hist",  32'(hist0),  32'hB);
      chk("gap_count", 32'(count0), 32'd1);
      chk("gap_full",  32'(full0),  32'(OV));

      // Reset mid-stream discards partial history.
      do_rst(1'b0, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      do_rst(1'b1, 1'b1);
      step(1'b1, 1'b1);
      chk("mid_match", 32'(match0), 32'h0);
      chk("mid_count", 32'(count0), 32'h0);
      chk("mid_hist",  32'(hist0),  32'h1);
      chk("mid_full",  32'(full0),  32'h0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      chk("mid_nomatch", 32'(match0), 32'h0);
      step(1'b1, 1'b1);
      chk("mid_match4", 32'(match0), 32'h1);
      chk("mid_count4", 32'(count0), 32'd1);

      // All-zeros pattern right after reset.
      do_rst(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0);
         chk($sformatf("z_match%0d", i), 32'(match1), 32'(zm[i]));
      end
      chk("z_count", 32'(count1), OV ? 32'd2 : 32'd1);
      chk("z_hist",  32'(hist1),  32'h0);

      // Saturating 2-bit counter over six hits of 1111.
      do_rst(1'b0, 1'b0);
      hits  = 0;
      nones = OV ? 9 : 24;
      for (int i = 0; i < nones; i++) begin
         step(1'b1, 1'b1);
         exp_m = OV ? (i >= 3) : ((i % 4) == 3);
         if (exp_m) hits++;
         chk($sformatf("sat_match%0d", i), 32'(match2), 32'(exp_m));
         chk($sformatf("sat_count%0d", i), 32'(count2), (hits > 3) ? 32'd3 : 32'(hits));
      end
      chk("sat_hits", 32'(hits), 32'd6);
      chk("sat_hist", 32'(hist2), 32'hF);
      step(1'b0, 1'b1);
      chk("sat_idle_match", 32'(match2), 32'h0);
      chk("sat_idle_count", 32'(count2), 32'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
